fetch_stage: RTL

- IF stage plus IF/ID pipeline register of the 5-stage MIPS core; directly upstream of the hazard-detection (stall) unit.
- Owns the PC and computes next-PC from ID-stage redirect requests (beq / j / jal / jr) with one architectural delay slot.
- Drives instruction memory and presents the fetched instruction to ID; the stall unit reads that instruction.
- Freezes PC and the IF/ID register whenever stall is high.

---
 rtl/fetch_stage_if.sv | 31 +++
 rtl/fetch_stage.sv | 97 +++++++++
 2 files changed

// File: rtl/fetch_stage_if.sv
// Bus bundle between the fetch stage and its neighbours: the ID redirect inputs,
// the hazard-unit stall, the instruction-memory port and the IF/ID register outputs.
// The slave modport is the fetch stage's view; the master modport is the view of
// everything around it (ID, stall unit, instruction memory).
interface fetch_stage_if;
  logic        stall;
  logic [1:0]  npc_sel;
  logic [15:0] br_imm16;
  logic [25:0] j_imm26;
  logic [31:0] jr_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] IF_instr_ID;
  logic [31:0] IF_pc_ID;
  logic [31:0] IF_pc8_ID;
  logic        IF_exc_ID;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_fetch_cnt;

  modport slave (
    input  stall, npc_sel, br_imm16, j_imm26, jr_target, imem_rdata,
    output imem_addr, IF_instr_ID, IF_pc_ID, IF_pc8_ID, IF_exc_ID,
           perf_stall_cnt, perf_fetch_cnt
  );

  modport master (
    output stall, npc_sel, br_imm16, j_imm26, jr_target, imem_rdata,
    input  imem_addr, IF_instr_ID, IF_pc_ID, IF_pc8_ID, IF_exc_ID,
           perf_stall_cnt, perf_fetch_cnt
  );
endinterface

// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register of the 5-stage MIPS core.
// Owns the PC, resolves ID-stage redirects (beq/j/jal/jr) with one delay slot,
// flags illegal fetch addresses and freezes while the hazard unit stalls.
// Optional performance counters are built only when FETCH_PERF_EN is defined;
// otherwise both counter outputs are tied to zero.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter int          IMEM_WORDS = 4096
) (
  input  logic          clk,
  input  logic          reset_n,
  fetch_stage_if.slave  bus
);

  // Highest word address that may legally be fetched.
  localparam logic [31:0] IMEM_TOP = IMEM_BASE + 32'(4 * IMEM_WORDS) - 32'd4;

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_BR  = 2'b01;
  localparam logic [1:0] SEL_J   = 2'b10;
  localparam logic [1:0] SEL_JR  = 2'b11;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q;
  logic [31:0] pcid_q;
  logic        exc_q;

  logic [31:0] pcid_plus4;
  logic [31:0] br_off;
  logic        fetch_err;

  // The instruction in ID sits at pcid_q, so its redirect operands are relative
  // to pcid_q+4. PC already holds the delay slot, which therefore always issues.
  assign pcid_plus4 = pcid_q + 32'd4;
  assign br_off     = {{14{bus.br_imm16[15]}}, bus.br_imm16, 2'b00};

  // Misaligned or out-of-window fetch addresses are reported, not trapped here.
  assign fetch_err = (pc_q[1:0] != 2'b00) || (pc_q < IMEM_BASE) || (pc_q > IMEM_TOP);

  // Next-PC selection; all four encodings are meaningful, arithmetic wraps mod 2^32.
  always_comb begin
    pc_d = pc_q + 32'd4;
    case (bus.npc_sel)
      SEL_SEQ: pc_d = pc_q + 32'd4;
      SEL_BR:  pc_d = pcid_plus4 + br_off;
      SEL_J:   pc_d = {pcid_plus4[31:28], bus.j_imm26, 2'b00};
      SEL_JR:  pc_d = bus.jr_target;
      default: pc_d = pc_q + 32'd4;
    endcase
  end

  // PC and IF/ID register: advance when not stalled, replace faulting fetches with a nop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      pcid_q  <= RESET_PC;
      exc_q   <= 1'b0;
    end else if (!bus.stall) begin
      pc_q    <= pc_d;
      instr_q <= fetch_err ? 32'h0 : bus.imem_rdata;
      pcid_q  <= pc_q;
      exc_q   <= fetch_err;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.IF_instr_ID = instr_q;
  assign bus.IF_pc_ID    = pcid_q;
  assign bus.IF_pc8_ID   = pcid_q + 32'd8;
  assign bus.IF_exc_ID   = exc_q;

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] fetch_cnt_q;

  // Saturating counters: stall cycles and accepted fetches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= 32'h0;
      fetch_cnt_q <= 32'h0;
    end else if (bus.stall) begin
      if (stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_q <= stall_cnt_q + 32'd1;
    end else begin
      if (fetch_cnt_q != 32'hFFFF_FFFF) fetch_cnt_q <= fetch_cnt_q + 32'd1;
    end
  end

  assign bus.perf_stall_cnt = stall_cnt_q;
  assign bus.perf_fetch_cnt = fetch_cnt_q;
`else
  assign bus.perf_stall_cnt = 32'h0;
  assign bus.perf_fetch_cnt = 32'h0;
`endif

endmodule
